regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Write-port front end for the 32x32 register file.
- Merges two result sources onto the single register-file write port: the in-order pipeline writeback and the multi-cycle multiply/divide unit.
- Buffers multdiv results in a small FIFO while the pipeline owns the port, redirects exceptions to the status register, and drops writes to r0 and to the hardware-driven register.
- Exports a pending-write mask that hazard logic uses to stall readers of queued registers.

Parameters:
- DEPTH, 2, multdiv holding-FIFO entries (power of two, 2..4).
- STATUS_REG, 30, register that receives the exception code when a source flags an exception.
- LOCKED_REG, 8, hardware-driven register; software writes to it are discarded.

Ports:
- clock  in  1  system clock, all state on rising edge
- ctrl_reset  in  1  synchronous reset, active-low
- pipe_valid  in  1  pipeline writeback request this cycle (no backpressure; always accepted)
- pipe_reg  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- pipe_exc  in  1  pipeline result raised an exception
- pipe_exc_code  in  32  value written to STATUS_REG when pipe_exc=1
- md_valid  in  1  multdiv result available
- md_ready  out  1  arbiter can accept a multdiv result
- md_reg  in  5  multdiv destination register
- md_data  in  32  multdiv result
- md_exc  in  1  multdiv exception (divide by zero / overflow)
- md_exc_code  in  32  value written to STATUS_REG when md_exc=1
- ctrl_writeEnable  out  1  register-file write enable (registered)
- ctrl_writeReg  out  5  register-file write index (registered)
- data_writeReg  out  32  register-file write data (registered)
- pending_mask  out  32  bit i = 1 while a FIFO entry targets register i
- fifo_count  out  log2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (ctrl_reset=0 at a rising edge):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - FIFO emptied; fifo_count=0; pending_mask=0.
  - md_ready is held 0 combinationally while ctrl_reset=0.
  - Reset overrides all same-cycle requests; an accepted-but-unissued result is lost.
- Target resolution, applied on entry to the arbiter:
  - exc=1 → target=STATUS_REG, data=exc_code.
  - Otherwise target=reg, data=data.
  - A resolved target of 0 or LOCKED_REG becomes a null write: it consumes its issue slot but drives ctrl_writeEnable=0.
  - An exception redirect to STATUS_REG is never nulled.
- md_ready = (fifo_count < DEPTH) AND ctrl_reset. It depends on registered state only and has no combinational path from md_valid.
- A multdiv handshake occurs when md_valid & md_ready.
- Issue selection each cycle; exactly one source issues, in priority order:
  1. pipe_valid=1 → issue the pipeline result.
  2. Otherwise, FIFO non-empty → pop the head and issue it.
  3. Otherwise, handshake this cycle with an empty FIFO → bypass and issue the multdiv result directly.
  4. Otherwise → nothing issues; ctrl_writeEnable=0 next cycle.
- A handshaken multdiv result that does not issue the same cycle is pushed at the FIFO tail.
- Push and pop in the same cycle are legal; fifo_count is unchanged.
- Latency: an issued result appears on the write port on the next rising edge, for exactly one cycle.
  - Pipeline: fixed 1 cycle.
  - Multdiv: 1 cycle plus its FIFO wait.
- Ordering: multdiv results issue in handshake order. Pipeline results may overtake queued multdiv results.
- pending_mask = OR over valid FIFO entries of one-hot(resolved target), with null targets excluded. It is combinational from FIFO registers.
  - A bit clears in the cycle after the pop edge.
  - A bypassed result never sets a bit.
- Full FIFO: md_ready=0. md_valid is expected to hold its data until ready; the arbiter drops nothing.
- Sustained pipe_valid=1 starves the FIFO. This is by design: hazard logic stalls the pipeline on pending_mask hits.
- Pointers wrap modulo DEPTH. fifo_count saturates structurally at DEPTH; overflow is impossible by handshake.

Test Plan:
- Reset, then pipe_valid=1, pipe_reg=5, pipe_data=0x12345678 → next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x12345678; following cycle ctrl_writeEnable=0.
- FIFO empty, pipe_valid=0, md_valid=1, md_reg=3, md_data=0xA → bypass: write r3=0xA one cycle later; pending_mask stays 0.
- pipe_valid=1 for 4 cycles while md_valid=1 presents md_reg 9, 10, 11:
  - md_ready drops after 2 handshakes; pending_mask=0x00000600.
  - Once pipe_valid=0: r9 writes, then r10, then r11, in order; pending_mask returns to 0.
- pipe_exc=1, pipe_reg=7, pipe_exc_code=2 → write r30=2. md_exc=1, md_exc_code=5 → write r30=5.
- pipe_reg=0 and then pipe_reg=8 writes → ctrl_writeEnable=0 on both slots. A queued md_reg=8 → consumes one pop; no pending bit; no write.
- FIFO holding 2 entries, ctrl_reset=0 for one cycle → fifo_count=0, pending_mask=0, md_ready=0 during reset and 1 after; no stale writes issue.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Bundles both result sources, the register-file write port and the hazard
// status outputs of the write arbiter.
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_valid;
  logic [4:0]    pipe_reg;
  logic [31:0]   pipe_data;
  logic          pipe_exc;
  logic [31:0]   pipe_exc_code;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_reg;
  logic [31:0]   md_data;
  logic          md_exc;
  logic [31:0]   md_exc_code;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic [31:0]   pending_mask;
  logic [CW-1:0] fifo_count;

  modport master (
    output pipe_valid, pipe_reg, pipe_data, pipe_exc, pipe_exc_code,
    output md_valid, md_reg, md_data, md_exc, md_exc_code,
    input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  pending_mask, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data, pipe_exc, pipe_exc_code,
    input  md_valid, md_reg, md_data, md_exc, md_exc_code,
    output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output pending_mask, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback and multdiv results onto the single register-file
// write port, queueing multdiv results while the pipeline owns the port.
module regfile_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STATUS_REG = 30,
  parameter int LOCKED_REG = 8
) (
  input logic               clock,
  input logic               ctrl_reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [4:0]    STATUS_R = 5'(STATUS_REG);
  localparam logic [4:0]    LOCKED_R = 5'(LOCKED_REG);

  typedef struct packed {
    logic        we;
    logic [4:0]  tgt;
    logic [31:0] data;
  } wr_t;

  // Exception redirects are never nulled, even if STATUS_REG collides.
  function automatic wr_t resolve(input logic exc, input logic [4:0] rg,
                                  input logic [31:0] d, input logic [31:0] code);
    wr_t r;
    if (exc) begin
      r.we   = 1'b1;
      r.tgt  = STATUS_R;
      r.data = code;
    end else begin
      r.we   = (rg != 5'd0) && (rg != LOCKED_R);
      r.tgt  = rg;
      r.data = d;
    end
    return r;
  endfunction

  wr_t           fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          we_q;
  logic [4:0]    reg_q;
  logic [31:0]   data_q;

  wr_t  pipe_res, md_res, issue;
  logic hs, fifo_empty, pop, push, issue_any;

  assign fifo_empty   = (count == '0);
  assign bus.md_ready = (count < DEPTH_C) && ctrl_reset;
  assign hs           = bus.md_valid && bus.md_ready;

  always_comb begin
    pipe_res  = resolve(bus.pipe_exc, bus.pipe_reg, bus.pipe_data, bus.pipe_exc_code);
    md_res    = resolve(bus.md_exc, bus.md_reg, bus.md_data, bus.md_exc_code);
    issue     = '0;
    issue_any = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    if (bus.pipe_valid) begin
      issue     = pipe_res;
      issue_any = 1'b1;
      push      = hs;
    end else if (!fifo_empty) begin
      issue     = fifo_q[rd_ptr];
      issue_any = 1'b1;
      pop       = 1'b1;
      push      = hs;
    end else if (hs) begin
      issue     = md_res;
      issue_any = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      we_q <= issue_any && issue.we;
      if (issue_any) begin
        reg_q  <= issue.tgt;
        data_q <= issue.data;
      end
    end
  end

  // Storage needs no reset: push is blocked while ctrl_reset is low.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr] <= md_res;
  end

  always_comb begin
    logic [PW-1:0] slot;
    bus.pending_mask = '0;
    slot             = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if ((CW'(k) < count) && fifo_q[slot].we)
        bus.pending_mask[fifo_q[slot].tgt] = 1'b1;
    end
  end

  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = reg_q;
  assign bus.data_writeReg    = data_q;
  assign bus.fifo_count       = count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for the write arbiter against a queue-based model of the
// arbitration rules, preceded by short directed scenarios.
module tb_regfile_write_arbiter;
  localparam int DEPTH      = 2;
  localparam int STATUS_REG = 30;
  localparam int LOCKED_REG = 8;

  typedef struct {
    logic        exc;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] code;
  } req_t;

  typedef struct {
    logic        we;
    logic [4:0]  tgt;
    logic [31:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic ctrl_reset;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(
    .DEPTH(DEPTH), .STATUS_REG(STATUS_REG), .LOCKED_REG(LOCKED_REG)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus.slave)
  );

  always #5 clock = ~clock;

  int   n_chk  = 0;
  int   n_pass = 0;
  req_t md_src[$];
  ent_t model_q[$];
  logic armed = 1'b0;
  logic exp_we;
  logic exp_port_known;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic ent_t resolve(input req_t q);
    ent_t e;
    if (q.exc) begin
      e.we = 1'b1; e.tgt = 5'(STATUS_REG); e.data = q.code;
    end else begin
      e.we = (q.r != 5'd0) && (q.r != 5'(LOCKED_REG)); e.tgt = q.r; e.data = q.d;
    end
    return e;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (model_q[i]) if (model_q[i].we) m[model_q[i].tgt] = 1'b1;
    return m;
  endfunction

  function automatic req_t mkreq(input logic exc, input logic [4:0] r,
                                 input logic [31:0] d, input logic [31:0] code);
    req_t q;
    q.exc = exc; q.r = r; q.d = d; q.code = code;
    return q;
  endfunction

  // One cycle: check last cycle's predictions, drive new inputs, predict.
  task automatic step(input logic rst, input logic pv, input req_t p);
    logic mv, ready, hs, issued;
    req_t m;
    ent_t iss;
    @(negedge clock);
    if (armed) begin
      chk("write_enable", 32'(bus.ctrl_writeEnable), 32'(exp_we));
      if (exp_port_known) begin
        chk("write_reg", 32'(bus.ctrl_writeReg), 32'(exp_reg));
        chk("write_data", bus.data_writeReg, exp_data);
      end
      chk("pending_mask", bus.pending_mask, model_mask());
      chk("fifo_count", 32'(bus.fifo_count), model_q.size());
    end
    mv = (md_src.size() > 0);
    m  = mv ? md_src[0] : mkreq(1'b0, 5'd0, 32'd0, 32'd0);
    ctrl_reset        = rst;
    bus.pipe_valid    = pv;
    bus.pipe_reg      = p.r;
    bus.pipe_data     = p.d;
    bus.pipe_exc      = p.exc;
    bus.pipe_exc_code = p.code;
    bus.md_valid      = mv;
    bus.md_reg        = m.r;
    bus.md_data       = m.d;
    bus.md_exc        = m.exc;
    bus.md_exc_code   = m.code;
    #1;
    ready = rst && (model_q.size() < DEPTH);
    if (armed || !rst) chk("md_ready", 32'(bus.md_ready), 32'(ready));
    hs = mv && ready;
    if (hs) void'(md_src.pop_front());
    issued = 1'b0;
    iss    = resolve(mkreq(1'b0, 5'd0, 32'd0, 32'd0));
    if (!rst) begin
      model_q.delete();
      exp_we = 1'b0; exp_reg = '0; exp_data = '0; exp_port_known = 1'b1;
    end else begin
      if (pv) begin
        iss = resolve(p); issued = 1'b1;
        if (hs) model_q.push_back(resolve(m));
      end else if (model_q.size() > 0) begin
        iss = model_q.pop_front(); issued = 1'b1;
        if (hs) model_q.push_back(resolve(m));
      end else if (hs) begin
        iss = resolve(m); issued = 1'b1;
      end
      exp_we         = issued && iss.we;
      exp_reg        = iss.tgt;
      exp_data       = iss.data;
      exp_port_known = exp_we;
    end
    armed = 1'b1;
  endtask

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 5))
      0:       return 5'd0;
      1:       return 5'(LOCKED_REG);
      2:       return 5'(STATUS_REG);
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic req_t rand_req();
    return mkreq($urandom_range(0, 7) == 0, rand_reg(), $urandom(), $urandom());
  endfunction

  req_t idle;

  initial begin
    idle = mkreq(1'b0, 5'd0, 32'd0, 32'd0);
    step(1'b0, 1'b0, idle);
    step(1'b0, 1'b0, idle);
    // Single pipeline write, then idle slot.
    step(1'b1, 1'b1, mkreq(1'b0, 5'd5, 32'h12345678, 32'd0));
    step(1'b1, 1'b0, idle);
    step(1'b1, 1'b0, idle);
    // Multdiv bypass into an empty FIFO.
    md_src.push_back(mkreq(1'b0, 5'd3, 32'hA, 32'd0));
    step(1'b1, 1'b0, idle);
    step(1'b1, 1'b0, idle);
    // Pipeline holds the port while multdiv results queue and stall.
    md_src.push_back(mkreq(1'b0, 5'd9,  32'h9,  32'd0));
    md_src.push_back(mkreq(1'b0, 5'd10, 32'h10, 32'd0));
    md_src.push_back(mkreq(1'b0, 5'd11, 32'h11, 32'd0));
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, mkreq(1'b0, 5'(i), 32'(i), 32'd0));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, idle);
    // Exception redirects.
    step(1'b1, 1'b1, mkreq(1'b1, 5'd7, 32'hDEAD, 32'd2));
    md_src.push_back(mkreq(1'b1, 5'd4, 32'hBEEF, 32'd5));
    step(1'b1, 1'b0, idle);
    step(1'b1, 1'b0, idle);
    // Null writes to r0 and the locked register, including a queued one.
    step(1'b1, 1'b1, mkreq(1'b0, 5'd0, 32'h1, 32'd0));
    step(1'b1, 1'b1, mkreq(1'b0, 5'd8, 32'h2, 32'd0));
    md_src.push_back(mkreq(1'b0, 5'd8, 32'h3, 32'd0));
    step(1'b1, 1'b1, mkreq(1'b0, 5'd20, 32'h4, 32'd0));
    step(1'b1, 1'b0, idle);
    step(1'b1, 1'b0, idle);
    // Reset with a full FIFO drops its contents.
    md_src.push_back(mkreq(1'b0, 5'd12, 32'h12, 32'd0));
    md_src.push_back(mkreq(1'b0, 5'd13, 32'h13, 32'd0));
    step(1'b1, 1'b1, mkreq(1'b0, 5'd1, 32'h1, 32'd0));
    step(1'b1, 1'b1, mkreq(1'b0, 5'd2, 32'h2, 32'd0));
    step(1'b0, 1'b0, idle);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, idle);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (md_src.size() < 3 && $urandom_range(0, 2) == 0) md_src.push_back(rand_req());
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 55), rand_req());
    end
    md_src.delete();
    for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, idle);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
